// File: rtl/ctl_unit_datafield_seq.sv
// Data-field receive sequencer: collects i_length elements of BYTES_PER_ELEM bytes, then locks.
// Latency: valid_cmd -> WAIT next cycle; 3 cycles per byte plus one COUNT cycle per element; no backpressure.
module ctl_unit_datafield_seq #(
  parameter int BYTES_PER_ELEM = 2,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDX_W          = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rx_int,
  input  logic             i_valid_cmd,
  input  logic [CNT_W-1:0] i_length,
  input  logic             i_abort,
  input  logic             i_unlock,
  output logic             o_clear_flag,
  output logic             o_load_flag,
  output logic [IDX_W-1:0] o_byte_idx,
  output logic             o_elem_done,
  output logic [CNT_W-1:0] o_elem_count,
  output logic             o_done_flag,
  output logic             o_locked_flag,
  output logic             o_idle_flag,
  output logic             o_error_flag
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TLIM = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CLEAR, S_LOAD, S_COUNT, S_DONE, S_LOCKED, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_len_q;
  logic [CNT_W-1:0] r_elem_count;
  logic [IDX_W-1:0] r_byte_idx;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W:0]   w_cnt_p1;
  logic             w_busy;

  assign w_cnt_p1 = {1'b0, r_elem_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_busy   = (r_state == S_WAIT) || (r_state == S_CLEAR) ||
                    (r_state == S_LOAD) || (r_state == S_COUNT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_valid_cmd) w_next = (i_length == '0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        // A byte arriving on the expiry cycle takes precedence over the timeout.
        if (i_rx_int) w_next = S_CLEAR;
        else if ((TIMEOUT_CYCLES > 0) && (r_timer == TLIM)) w_next = S_ERROR;
      end
      S_CLEAR:  w_next = S_LOAD;
      S_LOAD:   w_next = (r_byte_idx == LAST) ? S_COUNT : S_WAIT;
      S_COUNT:  w_next = (w_cnt_p1 == {1'b0, r_len_q}) ? S_DONE : S_WAIT;
      S_DONE:   w_next = S_LOCKED;
      S_LOCKED: if (i_unlock) w_next = S_IDLE;
      S_ERROR:  if (i_unlock) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_busy && i_abort) w_next = S_ERROR;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_len_q      <= '0;
      r_elem_count <= '0;
      r_byte_idx   <= '0;
      r_timer      <= '0;
    end else begin
      r_state <= w_next;
      // Timer restarts on every WAIT entry, so it only runs while WAIT persists.
      if ((TIMEOUT_CYCLES > 0) && (r_state == S_WAIT) && (w_next == S_WAIT))
        r_timer <= r_timer + 1'b1;
      else
        r_timer <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_valid_cmd) begin
            r_len_q      <= i_length;
            r_elem_count <= '0;
            r_byte_idx   <= '0;
          end
        end
        S_LOAD: begin
          if (!i_abort && (r_byte_idx != LAST)) r_byte_idx <= r_byte_idx + 1'b1;
        end
        S_COUNT: begin
          if (!i_abort) begin
            r_elem_count <= w_cnt_p1[CNT_W-1:0];
            r_byte_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_idle_flag   = (r_state == S_IDLE);
  assign o_clear_flag  = (r_state == S_CLEAR);
  assign o_load_flag   = (r_state == S_LOAD);
  assign o_elem_done   = (r_state == S_COUNT);
  assign o_done_flag   = (r_state == S_DONE);
  assign o_locked_flag = (r_state == S_LOCKED);
  assign o_error_flag  = (r_state == S_ERROR);
  assign o_byte_idx    = r_byte_idx;
  assign o_elem_count  = r_elem_count;

endmodule
